// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control and the ALU control
// decoder: opcode values, ALUOp / PCSource / ALUSrcB select encodings, the
// controller state enum and the bundle of datapath control outputs.
package mips_ctrl_pkg;

  // Opcodes (instruction bits [31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp: shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PCSource mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUSrcB mux selects
  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  // Controller states; the encoding is visible on the debug state port
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // Datapath control bundle produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // True for the opcodes DECODE can dispatch
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec
// Combinational decode of the controller state into datapath controls.
// Ports:
//   state     in  state_t : current controller state
//   mem_ready in  1       : memory completes the current access this cycle
//   ctrl      out ctrl_t  : all datapath enables / selects plus instr_done
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Every control defaults to zero; each state raises only what it needs.
  // The memory-handshake states also look at mem_ready so the IR/PC update
  // and the store retirement happen exactly in the completing cycle.
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SHL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control
// Multicycle MIPS main control unit: steps each instruction through
// fetch / decode / execute / memory / write-back and drives the datapath.
// Ports:
//   clk, reset       : clock (rising edge), async active-high reset
//   opcode     in 6  : IR[31:26], meaningful in DECODE and MEMADR
//   mem_ready  in 1  : memory access completes this cycle
//   PCWrite .. ALUSrcA, PCSource, ALUSrcB, ALUOp : datapath controls
//   instr_done out 1 : pulse in the last cycle of a retired instruction
//   illegal_op out 1 : pulse when DECODE sees an unsupported opcode
//   state      out 4 : current state encoding (debug)
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register; reset forces IDLE immediately, aborting any instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Unsupported opcodes and the unused encodings 13-15
  // fall back to FETCH so the controller always recovers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Output stage: unpack the decoded bundle and flag illegal opcodes
  always_comb begin
    PCWrite     = ctrl.pc_write;
    PCWriteCond = ctrl.pc_write_cond;
    IorD        = ctrl.iord;
    MemRead     = ctrl.mem_read;
    MemWrite    = ctrl.mem_write;
    MemtoReg    = ctrl.mem_to_reg;
    IRWrite     = ctrl.ir_write;
    RegWrite    = ctrl.reg_write;
    RegDst      = ctrl.reg_dst;
    ALUSrcA     = ctrl.alu_src_a;
    PCSource    = ctrl.pc_source;
    ALUSrcB     = ctrl.alu_src_b;
    ALUOp       = ctrl.alu_op;
    instr_done  = ctrl.instr_done;
    illegal_op  = (state_q == S_DECODE) && !op_supported(opcode);
    state       = state_q;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. Its 2-bit `ALUOp` output feeds the ALU control decoder directly. It waits on a memory-ready handshake for every instruction or data access.

## Interface
- No parameters. Widths are fixed by the MIPS ISA.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instruction register bits [31:26]. Valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: datapath controls.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- `ALUSrcB` out 2: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = decode funct.
- `instr_done` out 1: one-cycle pulse in the final cycle of a retired instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12. Encodings 13–15 are unreachable and go to FETCH.
- Transitions:
  - IDLE→FETCH.
  - FETCH→DECODE when `mem_ready`=1, else stay in FETCH.
  - DECODE dispatches on opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX. Any other opcode→FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when `mem_ready`=1, else stay.
  - MEMWR→FETCH when `mem_ready`=1, else stay.
  - EXEC→RWB; ADDIEX→ADDIWB.
  - MEMWB, RWB, BRANCH, JUMP and ADDIWB→FETCH.
- Outputs are zero unless listed for the state:
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are asserted only in the cycle where `mem_ready`=1.
  - DECODE: ALUSrcB=11, ALUOp=00 (branch target computation).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1. Held until `mem_ready`.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- `instr_done` is asserted in MEMWB, RWB, BRANCH, JUMP, ADDIWB, and in MEMWR when `mem_ready`=1.
- `illegal_op` is asserted in DECODE when the opcode is unsupported. `instr_done` stays 0 in that case.
- `opcode` is ignored outside DECODE and MEMADR.

## Timing
- Reset: `state` goes to IDLE immediately, without waiting for a clock edge. All outputs are 0 while `reset`=1 and during the IDLE cycle.
- Reset mid-instruction aborts it. The block restarts at IDLE and no further PCWrite or RegWrite is issued for the aborted instruction.
- Outputs depend only on `state`, except the FETCH IRWrite/PCWrite and MEMWR `instr_done` terms, which are also gated by `mem_ready`.
- Latency with `mem_ready` held at 1, counted from FETCH entry to the `instr_done` cycle inclusive:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready`=1 in any state other than FETCH, MEMRD or MEMWR is ignored.
- The first FETCH is the cycle after IDLE. IDLE is entered only from reset.

## Structure
- Shared package `mips_ctrl_pkg`: opcode constants, ALUOp constants (ADD 00, SUB 01, FUNCT 10), PCSource and ALUSrcB constants, and a state enum with the encodings above. The ALU control decoder imports the same ALUOp constants.
- The state register and next-state logic live in this module.
- One combinational sub-module is natural: `mips_ctrl_outdec`, mapping (`state`, `mem_ready`) to the control outputs.

## Test plan
- Reset with `mem_ready`=1 and `opcode`=100011, release → state sequence 0,1,2,3,4,5,1. `instr_done`=1 only in state 5, with RegWrite=1 and MemtoReg=1.
- Assert `reset` while in MEMRD → `state`=0 and all outputs 0 before the next edge. The next sequence starts with IDLE then FETCH. No RegWrite is seen for the aborted lw.
- `opcode`=000000 → EXEC drives ALUOp=10 and ALUSrcA=1. RWB follows with RegDst=1 and RegWrite=1. Instruction takes 4 cycles.
- `opcode`=000100, then `opcode`=000010 → BRANCH drives ALUOp=01, PCWriteCond=1, PCSource=01. JUMP drives PCWrite=1, PCSource=10. Each takes 3 cycles.
- sw with `mem_ready` held at 0 for 3 cycles in both FETCH and MEMWR → PCWrite and IRWrite pulse once. MemWrite stays high for 4 cycles. Total latency is 10 cycles.
- `opcode`=111111 at DECODE → `illegal_op`=1 for one cycle, `instr_done`=0, next state FETCH.
